// File: rtl/cpu_defs.sv
// Shared definitions for the EXE-stage multiply/divide sequencer:
// operation codes, sequencer states and the HI/LO commit selection.
package cpu_defs;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_WAIT,
        ST_DIV_WAIT,
        ST_DRAIN
    } md_state_e;

    typedef enum logic [2:0] {
        HL_NONE,
        HL_MTHI,
        HL_MTLO,
        HL_DIVZ,
        HL_MUL,
        HL_DIV
    } hilo_sel_e;

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair. The sequencer picks which result
// source is committed; each register has its own write enable.
module hilo_reg
    import cpu_defs::*;
#(
    parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  hilo_sel_e   sel,
    input  logic [31:0] src1,
    input  logic [63:0] product,
    input  logic [31:0] quotient,
    input  logic [31:0] remainder,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic [31:0] hi_d;
    logic [31:0] hi_q;
    logic [31:0] lo_d;
    logic [31:0] lo_q;

    // Commit mux: decode the selected source into per-register enables and data.
    always_comb begin
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_wdata = src1;
        lo_wdata = src1;
        case (sel)
            HL_MTHI: hi_we = 1'b1;
            HL_MTLO: lo_we = 1'b1;
            HL_DIVZ: begin
                hi_we    = 1'b1;
                lo_we    = 1'b1;
                lo_wdata = DIV_ZERO_LO;
            end
            HL_MUL: begin
                hi_we    = 1'b1;
                lo_we    = 1'b1;
                hi_wdata = product[63:32];
                lo_wdata = product[31:0];
            end
            HL_DIV: begin
                hi_we    = 1'b1;
                lo_we    = 1'b1;
                hi_wdata = remainder;
                lo_wdata = quotient;
            end
            default: ;
        endcase
        hi_d = hi_we ? hi_wdata : hi_q;
        lo_d = lo_we ? lo_wdata : lo_q;
    end

    // HI/LO storage, cleared on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/muldiv_sched.sv
// EXE-stage multiply/divide sequencer: accepts HI/LO-writing operations,
// launches the shared iterative multiplier or divider, commits results into
// HI/LO, stalls MFHI/MFLO while a result is outstanding and drops a running
// operation on a pipeline flush.
module muldiv_sched
    import cpu_defs::*;
#(
    parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_src1,
    input  logic [31:0] op_src2,
    output logic        op_ready,
    output logic        op_done,
    input  logic        flush,
    output logic        mult_begin,
    output logic        mult_signed,
    output logic [31:0] mult_op1,
    output logic [31:0] mult_op2,
    input  logic [63:0] product,
    input  logic        mult_end,
    output logic        div_begin,
    output logic        div_signed,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic [31:0] quotient,
    input  logic [31:0] remainder,
    input  logic        div_end,
    input  logic        rd_hi,
    input  logic        rd_lo,
    output logic        rd_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state_d;
    md_state_e   state_q;
    logic [31:0] op1_d;
    logic [31:0] op1_q;
    logic [31:0] op2_d;
    logic [31:0] op2_q;
    logic        mult_signed_d;
    logic        mult_signed_q;
    logic        div_signed_d;
    logic        div_signed_q;
    logic        done_d;
    logic        done_q;
    hilo_sel_e   hilo_sel;

    // Next-state, launch pulses, commit selection and done generation.
    always_comb begin
        state_d       = state_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        mult_signed_d = mult_signed_q;
        div_signed_d  = div_signed_q;
        done_d        = 1'b0;
        hilo_sel      = HL_NONE;
        op_ready      = 1'b0;
        mult_begin    = 1'b0;
        div_begin     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                op_ready = op_valid;
                if (op_valid && !flush) begin
                    case (op_code)
                        MD_MULT, MD_MULTU: begin
                            mult_begin    = 1'b1;
                            op1_d         = op_src1;
                            op2_d         = op_src2;
                            mult_signed_d = (op_code == MD_MULT);
                            state_d       = ST_MUL_WAIT;
                        end
                        MD_DIV, MD_DIVU: begin
                            if (op_src2 == 32'd0) begin
                                hilo_sel = HL_DIVZ;
                                done_d   = 1'b1;
                            end else begin
                                div_begin    = 1'b1;
                                op1_d        = op_src1;
                                op2_d        = op_src2;
                                div_signed_d = (op_code == MD_DIV);
                                state_d      = ST_DIV_WAIT;
                            end
                        end
                        MD_MTHI: begin
                            hilo_sel = HL_MTHI;
                            done_d   = 1'b1;
                        end
                        MD_MTLO: begin
                            hilo_sel = HL_MTLO;
                            done_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL_WAIT: begin
                if (flush) begin
                    state_d = mult_end ? ST_IDLE : ST_DRAIN;
                end else if (mult_end) begin
                    hilo_sel = HL_MUL;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DIV_WAIT: begin
                if (flush) begin
                    state_d = div_end ? ST_IDLE : ST_DRAIN;
                end else if (div_end) begin
                    hilo_sel = HL_DIV;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (mult_end || div_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state, operand/sign registers and the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op1_q         <= '0;
            op2_q         <= '0;
            mult_signed_q <= 1'b0;
            div_signed_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            mult_signed_q <= mult_signed_d;
            div_signed_q  <= div_signed_d;
            done_q        <= done_d;
        end
    end

    // During the launch cycle the operands bypass the registers so the unit
    // sees valid values alongside its begin pulse.
    assign mult_op1    = mult_begin ? op_src1 : op1_q;
    assign mult_op2    = mult_begin ? op_src2 : op2_q;
    assign mult_signed = mult_begin ? (op_code == MD_MULT) : mult_signed_q;
    assign div_op1     = div_begin ? op_src1 : op1_q;
    assign div_op2     = div_begin ? op_src2 : op2_q;
    assign div_signed  = div_begin ? (op_code == MD_DIV) : div_signed_q;

    assign op_done  = done_q;
    assign rd_stall = (state_q != ST_IDLE) && (rd_hi || rd_lo);

    hilo_reg #(
        .DIV_ZERO_LO(DIV_ZERO_LO)
    ) u_hilo (
        .clk      (clk),
        .reset    (reset),
        .sel      (hilo_sel),
        .src1     (op_src1),
        .product  (product),
        .quotient (quotient),
        .remainder(remainder),
        .hi       (hi),
        .lo       (lo)
    );

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched. The bench plays the role of the
// external multiplier/divider and keeps its own HI/LO model computed with
// plain arithmetic from each transaction.
module tb_muldiv_sched;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_src1;
    logic [31:0] op_src2;
    logic        op_ready;
    logic        op_done;
    logic        flush;
    logic        mult_begin;
    logic        mult_signed;
    logic [31:0] mult_op1;
    logic [31:0] mult_op2;
    logic [63:0] product;
    logic        mult_end;
    logic        div_begin;
    logic        div_signed;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_end;
    logic        rd_hi;
    logic        rd_lo;
    logic        rd_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [31:0] mdlHi = 32'd0;
    logic [31:0] mdlLo = 32'd0;

    muldiv_sched dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .op_src1    (op_src1),
        .op_src2    (op_src2),
        .op_ready   (op_ready),
        .op_done    (op_done),
        .flush      (flush),
        .mult_begin (mult_begin),
        .mult_signed(mult_signed),
        .mult_op1   (mult_op1),
        .mult_op2   (mult_op2),
        .product    (product),
        .mult_end   (mult_end),
        .div_begin  (div_begin),
        .div_signed (div_signed),
        .div_op1    (div_op1),
        .div_op2    (div_op2),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_end    (div_end),
        .rd_hi      (rd_hi),
        .rd_lo      (rd_lo),
        .rd_stall   (rd_stall),
        .hi         (hi),
        .lo         (lo)
    );

    // Free-running pipeline clock.
    always #5 clk = ~clk;

    // Count one comparison and report it if observed and expected differ.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Run one complete transaction from the low clock phase: accept, optional
    // wait with the bench acting as the unit, then commit and done checks.
    task automatic applyStimulus(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                                 input int latency, input int flushAt, input bit holdRdLo);
        logic        isMul;
        logic        isDiv;
        logic        isSigned;
        logic        flushed;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] prod;
        logic [31:0] q;
        logic [31:0] r;
        int          sa;
        int          sb;
        isMul    = (code == MD_MULT) || (code == MD_MULTU);
        isDiv    = ((code == MD_DIV) || (code == MD_DIVU)) && (b != 32'd0);
        isSigned = (code == MD_MULT) || (code == MD_DIV);
        ea   = isSigned ? {{32{a[31]}}, a} : {32'd0, a};
        eb   = isSigned ? {{32{b[31]}}, b} : {32'd0, b};
        prod = ea * eb;
        q = 32'd0;
        r = 32'd0;
        if (isDiv) begin
            if (isSigned) begin
                sa = $signed(a);
                sb = $signed(b);
                q  = 32'(sa / sb);
                r  = 32'(sa % sb);
            end else begin
                q = a / b;
                r = a % b;
            end
        end

        op_valid = 1'b1;
        op_code  = code;
        op_src1  = a;
        op_src2  = b;
        flush    = 1'b0;
        rd_hi    = 1'b0;
        rd_lo    = 1'b0;
        #1;
        checkOutput("accept_ready", 64'(op_ready), 64'd1);
        checkOutput("mult_begin", 64'(mult_begin), 64'(isMul));
        checkOutput("div_begin", 64'(div_begin), 64'(isDiv));
        if (isMul) begin
            checkOutput("launch_mult_op1", 64'(mult_op1), 64'(a));
            checkOutput("launch_mult_op2", 64'(mult_op2), 64'(b));
            checkOutput("launch_mult_signed", 64'(mult_signed), 64'(isSigned));
        end
        if (isDiv) begin
            checkOutput("launch_div_op1", 64'(div_op1), 64'(a));
            checkOutput("launch_div_op2", 64'(div_op2), 64'(b));
            checkOutput("launch_div_signed", 64'(div_signed), 64'(isSigned));
        end
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        op_code  = 3'($urandom_range(0, 7));
        op_src1  = $urandom;
        op_src2  = $urandom;

        if (!isMul && !isDiv) begin
            case (code)
                MD_MTHI: mdlHi = a;
                MD_MTLO: mdlLo = a;
                MD_DIV, MD_DIVU: begin
                    mdlHi = a;
                    mdlLo = 32'hFFFF_FFFF;
                end
                default: ;
            endcase
            rd_hi = 1'b1;
            rd_lo = 1'b1;
            #1;
            checkOutput("imm_hi", 64'(hi), 64'(mdlHi));
            checkOutput("imm_lo", 64'(lo), 64'(mdlLo));
            checkOutput("imm_done", 64'(op_done), 64'(code <= MD_MTLO));
            checkOutput("imm_rd_stall", 64'(rd_stall), 64'd0);
            @(posedge clk);
            @(negedge clk);
            rd_hi = 1'b0;
            rd_lo = 1'b0;
            #1;
            checkOutput("imm_done_clear", 64'(op_done), 64'd0);
            return;
        end

        flushed = 1'b0;
        for (int cyc = 1; cyc <= latency; cyc++) begin
            if (cyc > 1) @(negedge clk);
            op_valid  = 1'($urandom_range(0, 1));
            op_code   = 3'($urandom_range(0, 5));
            op_src1   = $urandom;
            op_src2   = $urandom;
            rd_hi     = 1'($urandom_range(0, 1));
            rd_lo     = holdRdLo ? 1'b1 : 1'($urandom_range(0, 1));
            flush     = (cyc == flushAt);
            mult_end  = isMul && (cyc == latency);
            div_end   = isDiv && (cyc == latency);
            product   = mult_end ? prod : {$urandom, $urandom};
            quotient  = div_end ? q : $urandom;
            remainder = div_end ? r : $urandom;
            #1;
            checkOutput("wait_ready", 64'(op_ready), 64'd0);
            checkOutput("wait_mult_begin", 64'(mult_begin), 64'd0);
            checkOutput("wait_div_begin", 64'(div_begin), 64'd0);
            checkOutput("wait_rd_stall", 64'(rd_stall), 64'(rd_hi | rd_lo));
            checkOutput("wait_done", 64'(op_done), 64'd0);
            checkOutput("wait_hi", 64'(hi), 64'(mdlHi));
            checkOutput("wait_lo", 64'(lo), 64'(mdlLo));
            if (isMul) begin
                checkOutput("hold_mult_op1", 64'(mult_op1), 64'(a));
                checkOutput("hold_mult_op2", 64'(mult_op2), 64'(b));
                checkOutput("hold_mult_signed", 64'(mult_signed), 64'(isSigned));
            end else begin
                checkOutput("hold_div_op1", 64'(div_op1), 64'(a));
                checkOutput("hold_div_op2", 64'(div_op2), 64'(b));
                checkOutput("hold_div_signed", 64'(div_signed), 64'(isSigned));
            end
            if (flush) flushed = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        mult_end = 1'b0;
        div_end  = 1'b0;
        flush    = 1'b0;
        op_valid = 1'b0;
        rd_hi    = 1'b0;
        rd_lo    = 1'b1;
        if (!flushed) begin
            if (isMul) begin
                mdlHi = prod[63:32];
                mdlLo = prod[31:0];
            end else begin
                mdlHi = r;
                mdlLo = q;
            end
        end
        #1;
        checkOutput("commit_hi", 64'(hi), 64'(mdlHi));
        checkOutput("commit_lo", 64'(lo), 64'(mdlLo));
        checkOutput("commit_done", 64'(op_done), 64'(!flushed));
        checkOutput("commit_rd_stall", 64'(rd_stall), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rd_lo = 1'b0;
        #1;
        checkOutput("commit_done_clear", 64'(op_done), 64'd0);
    endtask

    initial begin
        logic [2:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;
        int          fa;

        reset     = 1'b1;
        op_valid  = 1'b0;
        op_code   = 3'd0;
        op_src1   = 32'd0;
        op_src2   = 32'd0;
        flush     = 1'b0;
        product   = 64'd0;
        mult_end  = 1'b0;
        quotient  = 32'd0;
        remainder = 32'd0;
        div_end   = 1'b0;
        rd_hi     = 1'b0;
        rd_lo     = 1'b0;
        #2;
        checkOutput("rst_hi", 64'(hi), 64'd0);
        checkOutput("rst_lo", 64'(lo), 64'd0);
        checkOutput("rst_done", 64'(op_done), 64'd0);
        checkOutput("rst_ready", 64'(op_ready), 64'd0);
        checkOutput("rst_mult_begin", 64'(mult_begin), 64'd0);
        checkOutput("rst_div_begin", 64'(div_begin), 64'd0);
        checkOutput("rst_mult_op1", 64'(mult_op1), 64'd0);
        checkOutput("rst_div_op2", 64'(div_op2), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;

        // Directed cases.
        applyStimulus(MD_MULT, 32'hFFFF_FFFD, 32'd7, 5, 0, 1'b0);
        checkOutput("mult_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        checkOutput("mult_neg_lo", 64'(lo), 64'hFFFF_FFEB);
        applyStimulus(MD_DIVU, 32'd100, 32'd7, 4, 0, 1'b1);
        checkOutput("divu_lo", 64'(lo), 64'd14);
        checkOutput("divu_hi", 64'(hi), 64'd2);
        applyStimulus(MD_DIV, 32'h55, 32'd0, 1, 0, 1'b0);
        checkOutput("divz_hi", 64'(hi), 64'h55);
        checkOutput("divz_lo", 64'(lo), 64'hFFFF_FFFF);
        applyStimulus(MD_MTHI, 32'h1234, 32'd0, 1, 0, 1'b0);
        checkOutput("mthi_hi", 64'(hi), 64'h1234);
        applyStimulus(MD_MULTU, 32'hDEAD_BEEF, 32'h10, 5, 2, 1'b0);
        applyStimulus(MD_DIV, 32'hFFFF_FF9C, 32'd7, 3, 3, 1'b0);
        applyStimulus(MD_MULT, 32'd6, 32'hFFFF_FFF9, 2, 0, 1'b0);
        applyStimulus(MD_DIV, 32'hFFFF_FF9C, 32'd7, 3, 0, 1'b1);
        applyStimulus(3'd6, 32'hAAAA_AAAA, 32'd1, 1, 0, 1'b0);

        // Flush in IDLE blocks acceptance.
        op_valid = 1'b1;
        op_code  = MD_MTLO;
        op_src1  = 32'hCAFE_F00D;
        flush    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_code = MD_MULT;
        #1;
        checkOutput("idle_flush_no_begin", 64'(mult_begin), 64'd0);
        checkOutput("idle_flush_lo", 64'(lo), 64'(mdlLo));
        checkOutput("idle_flush_done", 64'(op_done), 64'd0);
        @(negedge clk);
        op_valid = 1'b0;
        flush    = 1'b0;
        #1;

        // Reset during DIV_WAIT, then a late end pulse must be ignored.
        applyStimulus(MD_MTLO, 32'h0BAD_0BAD, 32'd0, 1, 0, 1'b0);
        op_valid = 1'b1;
        op_code  = MD_DIV;
        op_src1  = 32'd1000;
        op_src2  = 32'd3;
        #1;
        checkOutput("rstdiv_begin", 64'(div_begin), 64'd1);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        rd_lo    = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midrst_hi", 64'(hi), 64'd0);
        checkOutput("midrst_lo", 64'(lo), 64'd0);
        checkOutput("midrst_done", 64'(op_done), 64'd0);
        checkOutput("midrst_rd_stall", 64'(rd_stall), 64'd0);
        checkOutput("midrst_div_signed", 64'(div_signed), 64'd0);
        checkOutput("midrst_div_op1", 64'(div_op1), 64'd0);
        checkOutput("midrst_ready", 64'(op_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        rd_lo = 1'b0;
        mdlHi = 32'd0;
        mdlLo = 32'd0;
        @(negedge clk);
        div_end   = 1'b1;
        quotient  = 32'd333;
        remainder = 32'd1;
        @(posedge clk);
        @(negedge clk);
        div_end = 1'b0;
        #1;
        checkOutput("late_end_hi", 64'(hi), 64'd0);
        checkOutput("late_end_lo", 64'(lo), 64'd0);
        checkOutput("late_end_done", 64'(op_done), 64'd0);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            rc  = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (rc == MD_DIV && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            lat = $urandom_range(1, 6);
            fa  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
            applyStimulus(rc, ra, rb, lat, fa, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Sequencer and HI/LO owner for the multi-cycle arithmetic units in the EXE stage of the five-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from EXE and launches the shared iterative multiplier or divider with a one-cycle begin pulse. It waits for the unit's end pulse, then commits the HI/LO registers. It also stalls MFHI/MFLO readers while a HI/LO write is pending, and discards a running operation on a pipeline flush.

## Interface
Parameters:
- `DIV_ZERO_LO`, default 32'hFFFF_FFFF, LO value committed on divide-by-zero.

Ports:
- `clk`  in  1  pipeline clock. One clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `op_valid`  in  1  EXE presents an operation this cycle.
- `op_code`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved, treated as no-op.
- `op_src1`, `op_src2`  in  32 each  rs and rt operand values.
- `op_ready`  out  1  operation accepted this cycle.
- `op_done`  out  1  one-cycle pulse when HI/LO have been committed.
- `flush`  in  1  exception/ERET cancel from WB.
- `mult_begin`  out  1  multiplier start pulse.
- `mult_signed`  out  1  multiplier sign mode.
- `mult_op1`, `mult_op2`  out  32 each  multiplier operands.
- `product`  in  64  multiplier result.
- `mult_end`  in  1  multiplier end pulse.
- `div_begin`  out  1  divider start pulse.
- `div_signed`  out  1  divider sign mode.
- `div_op1`, `div_op2`  out  32 each  divider operands.
- `quotient`, `remainder`  in  32 each  divider results.
- `div_end`  in  1  divider end pulse.
- `rd_hi`, `rd_lo`  in  1 each  MFHI/MFLO in EXE this cycle.
- `rd_stall`  out  1  reader must hold; HI/LO not yet final.
- `hi`, `lo`  out  32 each  architectural HI/LO.

## Operation
- States: IDLE, MUL_WAIT, DIV_WAIT, DRAIN.
- IDLE:
  - `op_ready` = `op_valid`; accepting `op_valid` & !`flush`.
  - MTHI/MTLO: write `op_src1` into HI or LO at the next edge; `op_done` asserted in the cycle after acceptance; stay IDLE.
  - MULT/MULTU: latch operands into the op registers and drive `mult_begin`=1 combinationally in the accept cycle → MUL_WAIT.
  - DIV/DIVU with `op_src2`≠0: same, on the divider side → DIV_WAIT.
  - DIV/DIVU with `op_src2`=0: no divider launch. Commit HI=`op_src1`, LO=`DIV_ZERO_LO` next edge, `op_done` pulse, stay IDLE.
- MUL_WAIT: `op_ready`=0. On `mult_end`: HI=`product`[63:32], LO=`product`[31:0] at that edge → IDLE; `op_done` pulses in the cycle after the edge.
- DIV_WAIT: on `div_end`: LO=`quotient`, HI=`remainder` → IDLE.
- Flush:
  - `flush` in MUL_WAIT or DIV_WAIT → DRAIN. HI/LO untouched, no `op_done`.
  - DRAIN waits for the outstanding end pulse, discards the result, then → IDLE.
  - `flush` in IDLE blocks acceptance that cycle.
- `rd_stall` = (state≠IDLE) | (`op_done` pending commit) & (`rd_hi`|`rd_lo`). MT* readers in the very next cycle see the updated value with no stall: HI/LO is registered, commit precedes read.
- Sign: `mult_signed`/`div_signed` = (`op_code`==0)/(==2), registered with the operands.
- Operand registers drive `mult_op*`/`div_op*` stable from accept until end.
- End pulses arriving in IDLE are ignored.

## Timing
- Reset values: state IDLE; `hi`=`lo`=0; `op_ready`=`op_done`=`mult_begin`=`div_begin`=`rd_stall`=0; operand registers 0; `mult_signed`=`div_signed`=0.
- Latency:
  - MT*/div-by-zero commit 1 cycle after accept.
  - MUL/DIV commit at the `*_end` edge; `op_done` follows 1 cycle later.
- Begin pulses are exactly one cycle, never asserted outside IDLE.
- Simultaneous `flush` and `*_end` in a WAIT state: flush wins; no commit → IDLE directly, since the end has been consumed.
- `reset` mid-operation: immediate return to IDLE. The external unit is reset on the same `reset`.

## Structure
- Shared package `cpu_defs`: op_code constants (MD_MULT…MD_MTLO), state encoding.
- One natural sub-module: `hilo_reg`, holding the HI/LO registers with separate write enables and commit mux.
- The FSM stays in the top.

## Test plan
- MULT: `op_src1`=-3, `op_src2`=7, `mult_end` 5 cycles after `mult_begin`, `product`=64'hFFFF_FFFF_FFFF_FFEB → HI=FFFF_FFFF, LO=FFFF_FFEB, `op_done` 1 cycle later, `mult_signed`=1.
- DIVU: 100/7 → LO=14, HI=2, `div_signed`=0; `rd_lo` asserted throughout the wait → `rd_stall`=1 until the commit edge.
- DIV by zero: `op_src1`=0x55, `op_src2`=0 → no `div_begin`, HI=0x55, LO=FFFF_FFFF after 1 cycle.
- MTHI then MFHI back-to-back: `op_src1`=0x1234 → HI=0x1234 next cycle, `rd_stall`=0.
- Flush during MUL_WAIT, `mult_end` 3 cycles later → HI/LO unchanged, no `op_done`, back to IDLE; next MULT accepted normally.
- Assert `reset` during DIV_WAIT → all outputs at reset values immediately; a late `div_end` is ignored.
